cordic_core: RTL and testbench

- Bus-mapped CORDIC rotation engine that computes cosine and sine of a 32-bit binary angle.
- It is a memory-mapped peripheral: software writes an angle register, waits for `done`, then reads the cos and sin result registers.
- Iterative architecture: one micro-rotation per clock, with quadrant pre-reduction so any input angle is valid.

---
 rtl/cordic_core.sv | 156 +++++++++++++++
 tb/tb_cordic_core.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_core.sv
// Bus-mapped iterative CORDIC rotation engine: ANGLE write starts a cos/sin computation,
// one micro-rotation per clock after quadrant pre-reduction.
module cordic_core #(
  parameter int unsigned ITERATIONS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done
);

  localparam int unsigned DW = 34;
  localparam int unsigned CW = 5;
  localparam logic signed [DW-1:0] X_INIT  = 34'sh0_26DD_3B6A;
  localparam logic signed [DW-1:0] QUARTER = 34'sh0_2000_0000;
  localparam logic signed [DW-1:0] HALF    = 34'sh0_4000_0000;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FINISH} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         iter_q;
  logic signed [DW-1:0]  x_q, y_q, z_q;
  logic                  neg_q;
  logic [31:0]           angle_q, cos_q, sin_q;
  logic                  busy;
  logic                  angle_wr;
  logic signed [DW-1:0]  ang_ext, x_sh, y_sh, atan_i;

  // atan(2^-i) in binary-angle units (2^30 = 180 degrees)
  function automatic logic [31:0] atan_lut(input logic [CW-1:0] i);
    logic [31:0] v;
    v = '0;
    case (i)
      5'd0:  v = 32'h1000_0000;  5'd1:  v = 32'h0972_028E;
      5'd2:  v = 32'h04FD_9C2E;  5'd3:  v = 32'h0288_88EA;
      5'd4:  v = 32'h0145_86A2;  5'd5:  v = 32'h00A2_EBF1;
      5'd6:  v = 32'h0051_7B0F;  5'd7:  v = 32'h0028_BE2B;
      5'd8:  v = 32'h0014_5F2A;  5'd9:  v = 32'h000A_2F97;
      5'd10: v = 32'h0005_17CC;  5'd11: v = 32'h0002_8BE6;
      5'd12: v = 32'h0001_45F3;  5'd13: v = 32'h0000_A2FA;
      5'd14: v = 32'h0000_517D;  5'd15: v = 32'h0000_28BE;
      5'd16: v = 32'h0000_145F;  5'd17: v = 32'h0000_0A30;
      5'd18: v = 32'h0000_0518;  5'd19: v = 32'h0000_028C;
      5'd20: v = 32'h0000_0146;  5'd21: v = 32'h0000_00A3;
      5'd22: v = 32'h0000_0051;  5'd23: v = 32'h0000_0029;
      5'd24: v = 32'h0000_0014;  5'd25: v = 32'h0000_000A;
      5'd26: v = 32'h0000_0005;  5'd27: v = 32'h0000_0003;
      5'd28: v = 32'h0000_0001;  5'd29: v = 32'h0000_0001;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign angle_wr = bus_write && (addr == 6'h04);
  assign busy     = (state_q != IDLE);
  assign ang_ext  = {{3{angle_q[30]}}, angle_q[30:0]};
  assign x_sh     = x_q >>> iter_q;
  assign y_sh     = y_q >>> iter_q;
  assign atan_i   = {2'b00, atan_lut(iter_q)};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; an ANGLE write restarts from LOAD in any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      LOAD:    state_d = ITER;
      ITER:    if (iter_q == CW'(ITERATIONS - 1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (angle_wr) state_d = LOAD;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle_q <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      done    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      if (angle_wr) begin
        angle_q <= wdata;
        done    <= 1'b0;
      end
      case (state_q)
        LOAD: begin
          x_q    <= X_INIT;
          y_q    <= '0;
          iter_q <= '0;
          if (ang_ext > QUARTER) begin
            z_q   <= ang_ext - HALF;
            neg_q <= 1'b1;
          end else if (ang_ext < -QUARTER) begin
            z_q   <= ang_ext + HALF;
            neg_q <= 1'b1;
          end else begin
            z_q   <= ang_ext;
            neg_q <= 1'b0;
          end
        end
        ITER: begin
          iter_q <= iter_q + CW'(1);
          if (!z_q[DW-1]) begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_i;
          end else begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_i;
          end
        end
        FINISH: begin
          // A write landing on FINISH aborts this result
          if (!angle_wr) begin
            cos_q <= 32'(neg_q ? -x_q : x_q);
            sin_q <= 32'(neg_q ? -y_q : y_q);
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational register read, no side effects
  always_comb begin
    rdata = '0;
    if (bus_read) begin
      case (addr)
        6'h00:   rdata = {30'd0, busy, done};
        6'h04:   rdata = angle_q;
        6'h08:   rdata = cos_q;
        6'h0C:   rdata = sin_q;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_core.sv
// Directed plus random-angle bench for cordic_core; expected cos/sin come from real-valued trig.
module tb_cordic_core;

  localparam int unsigned ITERS = 30;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_write;
  logic        bus_read;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_angle;

  cordic_core #(.ITERATIONS(ITERS)) dut (
    .clk(clk), .rst(rst), .bus_write(bus_write), .bus_read(bus_read),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input int exp);
    longint diff;
    diff = longint'($signed(obs)) - longint'(exp);
    vectors++;
    assert (diff <= 64 && diff >= -64) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (+-64)", tag, $signed(obs), exp);
    end
  endtask

  // Ideal round(cos/sin * 2^30) of the angle taken modulo 360 degrees
  task automatic ref_cs(input logic [31:0] a, output int c, output int s);
    int  sa;
    real th, rc, rs;
    sa = $signed({a[30], a[30:0]});
    th = real'(sa) * PI / 1073741824.0;
    rc = $cos(th) * 1073741824.0;
    rs = $sin(th) * 1073741824.0;
    c = int'((rc >= 0.0) ? $rtoi(rc + 0.5) : $rtoi(rc - 0.5));
    s = int'((rs >= 0.0) ? $rtoi(rs + 0.5) : $rtoi(rs - 0.5));
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    bus_read = 1'b1;
    addr = a;
    #1;
    d = rdata;
    bus_read = 1'b0;
    addr = '0;
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] v);
    @(negedge clk);
    bus_write = 1'b1;
    addr = a;
    wdata = v;
    @(posedge clk);
    #1;
    bus_write = 1'b0;
    addr = '0;
    wdata = '0;
  endtask

  // Counts edges after the write until done is seen, bounded
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    chk_eq(tag, 32'(n), 32'(ITERS + 2));
  endtask

  task automatic check_result(input string tag);
    logic [31:0] d;
    int c, s;
    ref_cs(exp_angle, c, s);
    bus_rd(6'h08, d); chk_near({tag, "_cos"}, d, c);
    bus_rd(6'h0C, d); chk_near({tag, "_sin"}, d, s);
    bus_rd(6'h04, d); chk_eq({tag, "_angle"}, d, exp_angle);
    bus_rd(6'h00, d); chk_eq({tag, "_status_done"}, d, 32'h1);
  endtask

  task automatic run_angle(input string tag, input logic [31:0] v);
    logic [31:0] d;
    bus_wr(6'h04, v);
    exp_angle = v;
    bus_rd(6'h00, d); chk_eq({tag, "_status_busy"}, d, 32'h2);
    wait_done({tag, "_latency"});
    check_result(tag);
  endtask

  initial begin
    logic [31:0] d;
    int c, s;
    rst = 1'b0; bus_write = 1'b0; bus_read = 1'b0; addr = '0; wdata = '0;
    exp_angle = '0;
    #1;
    chk_eq("reset_done", 32'(done), 32'h0);
    bus_rd(6'h00, d); chk_eq("reset_status", d, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    bus_rd(6'h08, d); chk_eq("reset_cos", d, 32'h0);
    bus_rd(6'h04, d); chk_eq("reset_angle", d, 32'h0);

    // Directed angles including quadrant boundaries and wrap
    run_angle("deg0",    32'h0000_0000);
    run_angle("deg45",   32'h1000_0000);
    run_angle("deg90",   32'h2000_0000);
    run_angle("degm45",  32'hF000_0000);
    run_angle("deg180",  32'h4000_0000);
    run_angle("deg135",  32'h3000_0000);
    run_angle("degm90",  32'hE000_0000);
    run_angle("degm135", 32'hD000_0000);
    run_angle("bit31",   32'h8000_0000);
    run_angle("nearm180",32'h4000_0001);

    // Unmapped address: reads 0, write ignored
    bus_rd(6'h10, d); chk_eq("unmapped_read", d, 32'h0);
    bus_wr(6'h10, 32'h1234_5678);
    bus_rd(6'h04, d); chk_eq("unmapped_write_angle", d, exp_angle);
    bus_rd(6'h00, d); chk_eq("unmapped_write_status", d, 32'h1);

    // Read during write returns the pre-write value
    @(negedge clk);
    bus_write = 1'b1; bus_read = 1'b1; addr = 6'h04; wdata = 32'h0800_0000;
    #1;
    chk_eq("rw_same_cycle_old", rdata, exp_angle);
    @(posedge clk);
    #1;
    chk_eq("rw_after_edge_new", rdata, 32'h0800_0000);
    bus_write = 1'b0; bus_read = 1'b0; addr = '0; wdata = '0;
    exp_angle = 32'h0800_0000;
    wait_done("rw_latency");
    check_result("rw");

    // Restart while busy
    bus_wr(6'h04, 32'h1000_0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_eq("restart_done_low", 32'(done), 32'h0);
    end
    bus_wr(6'h04, 32'h0000_0000);
    exp_angle = 32'h0000_0000;
    wait_done("restart_latency");
    check_result("restart");
    ref_cs(32'h0, c, s);
    chk_eq("restart_ref_sanity", 32'(c), 32'h4000_0000);

    // Randomized angles
    for (int i = 0; i < 12; i++) begin
      run_angle("random", $urandom);
    end

    // Asynchronous reset mid-computation
    bus_wr(6'h04, 32'h3000_0000);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_eq("async_done", 32'(done), 32'h0);
    bus_rd(6'h00, d); chk_eq("async_status", d, 32'h0);
    bus_rd(6'h08, d); chk_eq("async_cos", d, 32'h0);
    bus_rd(6'h0C, d); chk_eq("async_sin", d, 32'h0);
    bus_rd(6'h04, d); chk_eq("async_angle", d, 32'h0);
    @(negedge clk); rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk_eq("post_reset_done", 32'(done), 32'h0);
    bus_rd(6'h00, d); chk_eq("post_reset_idle", d, 32'h0);

    exp_angle = 32'h0000_0000;
    run_angle("post_reset_deg0", 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
